// File: rtl/uart_rx_frame.sv
// UART receive deserializer: oversampled start/data/parity/stop framing with
// 3-sample majority vote per bit and one-cycle result strobes.
module uart_rx_frame #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [WIDTH-1:0]          P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stp_Err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic                      rx_meta, rx_s;
  logic [PRESCALE_WIDTH-1:0] presc_l, edge_cnt, half;
  logic                      par_en_l, par_typ_l, par_bad;
  logic [BW-1:0]             bit_cnt;
  logic [WIDTH-1:0]          shreg;
  logic                      s0, s1, vote, decide, bit_end, last_bit;

  assign half     = presc_l >> 1;
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign decide   = (edge_cnt == half + P_ONE);
  assign bit_end  = (edge_cnt == presc_l - P_ONE);
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (decide && vote) state_nxt = IDLE;
               else if (bit_end)   state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = par_en_l ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      // Leave half a bit early so a back-to-back start edge is never missed.
      STOP:    if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_l    <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_bad    <= 1'b0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      rx_meta    <= RX_IN;
      rx_s       <= rx_meta;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      if (edge_cnt == half - P_ONE) s0 <= rx_s;
      if (edge_cnt == half)         s1 <= rx_s;

      // The detection cycle is edge 0, so the counter enters START at 1.
      if (state == IDLE) begin
        if (!rx_s) begin
          edge_cnt  <= P_ONE;
          presc_l   <= Prescale;
          par_en_l  <= PAR_EN;
          par_typ_l <= PAR_TYP;
          par_bad   <= 1'b0;
          bit_cnt   <= '0;
        end
      end else begin
        edge_cnt <= bit_end ? '0 : edge_cnt + P_ONE;
      end

      case (state)
        START: if (decide && vote) edge_cnt <= '0;
        DATA: begin
          if (decide)  shreg   <= {vote, shreg[WIDTH-1:1]};
          if (bit_end) bit_cnt <= bit_cnt + BW'(1);
        end
        PARITY: if (decide) par_bad <= (vote != (^shreg ^ par_typ_l));
        STOP: if (decide) begin
          edge_cnt   <= '0;
          Stp_Err    <= !vote;
          Par_Err    <= par_bad;
          Data_Valid <= vote && !par_bad;
          if (vote && !par_bad) P_DATA <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule
